// File: rtl/cpc_sync_int.sv
// CPC Gate Array raster interrupt and monitor sync generator.
// Counts CRTC HSYNC falling edges into a 52-line interrupt counter and resyncs it to VSYNC.
module cpc_sync_int (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       CLKEN,
  input  logic       HSYNC_I,
  input  logic       VSYNC_I,
  input  logic       INT_ACK,
  input  logic       IRQ_CLR,
  output logic       INT,
  output logic       HSYNC_O,
  output logic       VSYNC_O,
  output logic       CSYNC,
  output logic [5:0] LCNT
);

  localparam logic [5:0] LINES_PER_INT = 6'd52;
  localparam logic [1:0] VDLY_LOAD     = 2'd2;
  localparam logic [2:0] VCNT_LOAD     = 3'd4;
  localparam logic [2:0] HCNT_MAX      = 3'd7;

  logic       hs_d;
  logic       vs_d;
  logic [1:0] vdly;
  logic [2:0] hcnt;
  logic [2:0] vcnt;

  logic       hs_evt;
  logic       vs_start;
  logic       resync;
  logic [5:0] lcnt_ack;
  logic [5:0] lcnt_inc;
  logic       int_ack_v;
  logic       wrap;
  logic [5:0] lcnt_nxt;
  logic       int_nxt;

  assign hs_evt   = CLKEN & hs_d & ~HSYNC_I;
  assign vs_start = CLKEN & ~vs_d & VSYNC_I;
  assign resync   = hs_evt & (vdly == 2'd1);

  // The 52-line wrap is detected on the raw count so an acknowledge landing on
  // the wrapping line still raises the interrupt; everything else sees bit 5 cleared.
  always_comb begin
    lcnt_ack  = INT_ACK ? {1'b0, LCNT[4:0]} : LCNT;
    int_ack_v = INT_ACK ? 1'b0 : INT;
    lcnt_inc  = LCNT + 6'd1;
    wrap      = (lcnt_inc == LINES_PER_INT);
    lcnt_nxt  = lcnt_ack;
    int_nxt   = int_ack_v;
    if (IRQ_CLR) begin
      lcnt_nxt = 6'd0;
      int_nxt  = 1'b0;
    end else if (resync) begin
      lcnt_nxt = 6'd0;
      if (lcnt_ack[5]) int_nxt = 1'b1;
    end else if (hs_evt) begin
      if (wrap) begin
        lcnt_nxt = 6'd0;
        int_nxt  = 1'b1;
      end else begin
        lcnt_nxt = lcnt_ack + 6'd1;
      end
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      LCNT <= 6'd0;
      INT  <= 1'b0;
    end else begin
      LCNT <= lcnt_nxt;
      INT  <= int_nxt;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      hcnt    <= 3'd0;
      HSYNC_O <= 1'b0;
      vdly    <= 2'd0;
      vcnt    <= 3'd0;
      VSYNC_O <= 1'b0;
    end else if (CLKEN) begin
      hs_d <= HSYNC_I;
      vs_d <= VSYNC_I;
      if (!HSYNC_I)             hcnt <= 3'd0;
      else if (hcnt != HCNT_MAX) hcnt <= hcnt + 3'd1;
      // Monitor HSYNC is delayed two ticks and cut off after four.
      HSYNC_O <= HSYNC_I && (hcnt >= 3'd2) && (hcnt <= 3'd5);
      // A coincident HSYNC event consumes the old vdly before the reload wins.
      if (vs_start)                    vdly <= VDLY_LOAD;
      else if (hs_evt && vdly != 2'd0) vdly <= vdly - 2'd1;
      if (!VSYNC_I) begin
        VSYNC_O <= 1'b0;
      end else if (resync) begin
        VSYNC_O <= 1'b1;
        vcnt    <= VCNT_LOAD;
      end else if (hs_evt && VSYNC_O) begin
        vcnt <= vcnt - 3'd1;
        if (vcnt == 3'd1) VSYNC_O <= 1'b0;
      end
    end
  end

  assign CSYNC = ~(HSYNC_O ^ VSYNC_O);

endmodule
